rep_encoder_fifo_ble: RTL and testbench
=======================================

Name: rep_encoder_fifo_ble

Overview:
Parametrised bit-repetition encoder for the BLE PHY TX header path. It buffers serial bits in an internal FIFO and emits each bit REP times on a valid/ready output. The repetition factor is run-time selectable; factor 1 gives bypass. It sits between the header bit source and the header modulator feed, and adds backpressure, occupancy flags, flush and overflow reporting.

Parameters:
AD, 7, FIFO address width; depth = 2**AD bits
RW, 3, width of rep_factor; legal factors 1..(2**RW-1)
DATA, 1, symbol width per FIFO entry (payload bits per repetition unit)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear of FIFO, output stage and error flag
run  in  1  drain enable; when low, no new bit is popped
rep_factor  in  RW  repetitions per bit; 0 is treated as 1
in_valid  in  1  input bit strobe
in_data  in  DATA  input bit(s)
in_ready  out  1  = !full; write accepted when in_valid && in_ready
out_valid  out  1  registered output valid
out_data  out  DATA  registered output data, held while out_valid && !out_ready
out_ready  in  1  downstream accept
full  out  1  FIFO holds 2**AD entries
empty  out  1  FIFO holds 0 entries
level  out  AD+1  FIFO occupancy 0..2**AD
overflow  out  1  sticky: set when in_valid && full; cleared by flush or reset
done  out  1  one-cycle pulse: last repetition accepted and FIFO empty

Behaviour:
- Reset (async, reset low): pointers=0, level=0, empty=1, full=0, in_ready=1, out_valid=0, out_data=0, rep_cnt=0, overflow=0, done=0, state=IDLE. RAM contents are not reset.
- FIFO: pointers are AD+1 bits wide. full = (MSBs differ && low bits equal); empty = pointers equal. level = wr_ptr - rd_ptr, modulo 2**(AD+1). Pointers wrap naturally.
- Write: in_valid && !full stores in_data at wr_ptr and increments it. A write while full is dropped and sets overflow. No write-through: a write and a pop on the same cycle are both honoured and level is unchanged.
- Output stage FSM, two states:
  - IDLE: out_valid=0. Go to EMIT when run && !empty. On that transition: pop one entry, out_data <= entry, rep_cnt <= 0, eff_rep <= max(rep_factor,1), out_valid <= 1.
  - EMIT: a beat is accepted when out_valid && out_ready.
    - Accepted and rep_cnt < eff_rep-1: rep_cnt++, out_data holds.
    - Accepted and rep_cnt == eff_rep-1 (last beat): if run && !empty, pop the next entry back-to-back with no bubble, reload eff_rep, rep_cnt=0, stay in EMIT. Otherwise go to IDLE, out_valid=0, and pulse done=1 if empty.
    - Not accepted: all outputs hold.
- rep_factor is sampled only at pop. Changes in mid-bit take effect on the next bit.
- Latency: write into an empty FIFO with run=1 gives out_valid one cycle after the write is registered, i.e. two clk edges after in_valid.
- Throughput with out_ready=1: exactly eff_rep beats per bit, continuous.
- run deasserted in EMIT: the current bit completes all its repetitions, then the FSM enters IDLE.
- flush: highest priority, same-cycle write or pop is ignored. Next cycle: pointers=0, empty=1, IDLE, out_valid=0, rep_cnt=0, overflow=0, done=0.
- Reset mid-operation: returns to the reset values above immediately (asynchronous).

Decomposition:
- Package rep_enc_ble_pkg holds:
  - state encoding: IDLE=1'b0, EMIT=1'b1
  - default constants for AD/RW
  - function eff_rep(f) = (f==0) ? 1 : f
- One sub-module, rep_enc_fifo_ble, holds the RAM, pointers, full/empty/level and overflow. The top level holds the FSM, repetition counter and handshake.

Test Plan:
- rep_factor=3, run=1, out_ready=1, write 1,0,1 -> out_data stream 1,1,1,0,0,0,1,1,1 on 9 consecutive out_valid cycles; done pulses once after the 9th beat.
- rep_factor=0 then 1, write 8 bits 0xA5 LSB-first -> 8 beats, one per bit, values equal to the input; factor 0 behaves identically to 1.
- run=0, write 128 bits with AD=7 -> full=1, level=128, in_ready=0; a 129th in_valid sets overflow=1 and level stays 128; flush -> empty=1, level=0, overflow=0.
- rep_factor=3, bit 1 loaded, out_ready toggled 1,0,0,1,1 -> out_data=1 holds; exactly 3 accepted beats; rep_cnt does not advance on stalled cycles.
- Change rep_factor from 3 to 5 during the 2nd beat of bit 0 (bits 0,1 queued) -> bit 0 gives 3 beats, bit 1 gives 5 beats.
- Assert reset during EMIT at rep_cnt=1 -> out_valid=0, level=0, empty=1 in the same cycle; after release, the first new write behaves as in scenario 1.

Source files
------------

// File: rtl/rep_enc_ble_pkg.sv
// Shared types, default sizes and helpers for the BLE header bit-repetition encoder.
package rep_enc_ble_pkg;

  localparam int AD_DEF   = 7;
  localparam int RW_DEF   = 3;
  localparam int DATA_DEF = 1;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // A factor of zero is not meaningful, so it repeats each bit once.
  function automatic int unsigned eff_rep(input int unsigned f);
    return (f == 0) ? 1 : f;
  endfunction

endpackage

// File: rtl/rep_enc_fifo_ble.sv
// Bit FIFO with wrap-bit pointers, occupancy flags and a sticky overflow flag.
module rep_enc_fifo_ble
  import rep_enc_ble_pkg::*;
#(
  parameter int AD   = AD_DEF,
  parameter int DATA = DATA_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            wr_en,
  input  logic [DATA-1:0] wr_data,
  input  logic            rd_en,
  output logic [DATA-1:0] rd_data,
  output logic            full,
  output logic            empty,
  output logic [AD:0]     level,
  output logic            overflow
);

  logic [DATA-1:0] ram [2**AD];
  logic [AD:0]     wr_ptr;
  logic [AD:0]     rd_ptr;
  logic            do_wr;
  logic            do_rd;

  assign full    = (wr_ptr[AD] != rd_ptr[AD]) && (wr_ptr[AD-1:0] == rd_ptr[AD-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = ram[rd_ptr[AD-1:0]];
  assign do_wr   = wr_en && !full && !flush;
  assign do_rd   = rd_en && !empty && !flush;

  always_ff @(posedge clk) begin
    if (do_wr) ram[wr_ptr[AD-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_wr)          wr_ptr   <= wr_ptr + 1'b1;
      if (do_rd)          rd_ptr   <= rd_ptr + 1'b1;
      if (wr_en && full)  overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/rep_encoder_fifo_ble.sv
// Repetition encoder: pops buffered bits and emits each one eff_rep times on a valid/ready port.
module rep_encoder_fifo_ble
  import rep_enc_ble_pkg::*;
#(
  parameter int AD   = AD_DEF,
  parameter int RW   = RW_DEF,
  parameter int DATA = DATA_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            run,
  input  logic [RW-1:0]   rep_factor,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  output logic            in_ready,
  output logic            out_valid,
  output logic [DATA-1:0] out_data,
  input  logic            out_ready,
  output logic            full,
  output logic            empty,
  output logic [AD:0]     level,
  output logic            overflow,
  output logic            done
);

  state_t          state, state_n;
  logic [RW-1:0]   rep_cnt, rep_cnt_n;
  logic [RW-1:0]   eff_q, eff_n;
  logic            valid_n, done_n, pop;
  logic [DATA-1:0] data_n, rd_data;

  rep_enc_fifo_ble #(.AD(AD), .DATA(DATA)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_en    (in_valid),
    .wr_data  (in_data),
    .rd_en    (pop),
    .rd_data  (rd_data),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow)
  );

  assign in_ready = !full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      rep_cnt   <= '0;
      eff_q     <= RW'(1);
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= valid_n;
      out_data  <= data_n;
      rep_cnt   <= rep_cnt_n;
      eff_q     <= eff_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n   = state;
    valid_n   = out_valid;
    data_n    = out_data;
    rep_cnt_n = rep_cnt;
    eff_n     = eff_q;
    done_n    = 1'b0;
    pop       = 1'b0;
    if (flush) begin
      state_n   = IDLE;
      valid_n   = 1'b0;
      rep_cnt_n = '0;
    end else begin
      case (state)
        IDLE: begin
          if (run && !empty) begin
            pop       = 1'b1;
            data_n    = rd_data;
            rep_cnt_n = '0;
            eff_n     = RW'(eff_rep(32'(rep_factor)));
            valid_n   = 1'b1;
            state_n   = EMIT;
          end
        end
        EMIT: begin
          if (out_valid && out_ready) begin
            if (rep_cnt != eff_q - RW'(1)) begin
              rep_cnt_n = rep_cnt + RW'(1);
            end else if (run && !empty) begin
              // Last beat accepted with more data waiting: reload without a bubble.
              pop       = 1'b1;
              data_n    = rd_data;
              rep_cnt_n = '0;
              eff_n     = RW'(eff_rep(32'(rep_factor)));
            end else begin
              state_n   = IDLE;
              valid_n   = 1'b0;
              rep_cnt_n = '0;
              done_n    = empty;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rep_encoder_fifo_ble.sv
// Directed self-checking bench for rep_encoder_fifo_ble.
module tb_rep_encoder_fifo_ble;
  localparam int AD = 7;
  localparam int RW = 3;
  localparam int DATA = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            flush = 1'b0;
  logic            run = 1'b0;
  logic [RW-1:0]   rep_factor = '0;
  logic            in_valid = 1'b0;
  logic [DATA-1:0] in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic [DATA-1:0] out_data;
  logic            out_ready = 1'b0;
  logic            full;
  logic            empty;
  logic [AD:0]     level;
  logic            overflow;
  logic            done;

  int total = 0;
  int bad = 0;
  logic [DATA-1:0] beats [$];
  int done_cnt = 0;
  int tick_no = 0;
  int first_beat = -1;

  rep_encoder_fifo_ble #(.AD(AD), .RW(RW), .DATA(DATA)) dut (
    .clk(clk), .reset(reset), .flush(flush), .run(run), .rep_factor(rep_factor),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .full(full), .empty(empty), .level(level), .overflow(overflow), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Drive inputs for the next rising edge and record the beat that edge will accept.
  task automatic tick(input logic iv, input logic [DATA-1:0] id, input logic rdy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = rdy;
    if (out_valid && out_ready) begin
      if (first_beat < 0) first_beat = tick_no;
      beats.push_back(out_data);
    end
    if (done) done_cnt++;
    tick_no++;
  endtask

  task automatic clear_mon();
    beats.delete();
    done_cnt = 0;
    tick_no = 0;
    first_beat = -1;
  endtask

  task automatic test_reset();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("FAIL reset_out_data got=%b want=0", out_data); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
  endtask

  task automatic test_rep3();
    logic [8:0] exp9;
    exp9 = 9'b111_000_111;
    rep_factor = 3'd3;
    run = 1'b1;
    clear_mon();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    repeat (15) tick(1'b0, 1'b0, 1'b1);
    total++; if (beats.size() !== 9) begin bad++; $display("FAIL rep3_count got=%0d want=9", beats.size()); end
    for (int i = 0; i < 9 && i < beats.size(); i++) begin
      total++; if (beats[i] !== exp9[8-i]) begin bad++; $display("FAIL rep3_beat%0d got=%b want=%b", i, beats[i], exp9[8-i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL rep3_done got=%0d want=1", done_cnt); end
    total++; if (first_beat !== 2) begin bad++; $display("FAIL rep3_latency got=%0d want=2", first_beat); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rep3_empty got=%b want=1", empty); end
  endtask

  task automatic test_bypass();
    logic [7:0] a5;
    a5 = 8'hA5;
    run = 1'b1;
    for (int f = 0; f < 2; f++) begin
      rep_factor = RW'(f);
      clear_mon();
      for (int i = 0; i < 8; i++) tick(1'b1, a5[i], 1'b1);
      repeat (6) tick(1'b0, 1'b0, 1'b1);
      total++; if (beats.size() !== 8) begin bad++; $display("FAIL bypass_f%0d_count got=%0d want=8", f, beats.size()); end
      for (int i = 0; i < 8 && i < beats.size(); i++) begin
        total++; if (beats[i] !== a5[i]) begin bad++; $display("FAIL bypass_f%0d_beat%0d got=%b want=%b", f, i, beats[i], a5[i]); end
      end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL bypass_f%0d_done got=%0d want=1", f, done_cnt); end
    end
  endtask

  task automatic test_full();
    run = 1'b0;
    rep_factor = 3'd1;
    clear_mon();
    for (int i = 0; i < 128; i++) tick(1'b1, DATA'(i[0]), 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL full_flag got=%b want=1", full); end
    total++; if (level !== 8'd128) begin bad++; $display("FAIL full_level got=%0d want=128", level); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL full_overflow_early got=%b want=0", overflow); end
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL overflow_set got=%b want=1", overflow); end
    total++; if (level !== 8'd128) begin bad++; $display("FAIL overflow_level got=%0d want=128", level); end
    total++; if (beats.size() !== 0) begin bad++; $display("FAIL run0_beats got=%0d want=0", beats.size()); end
    flush = 1'b1;
    tick(1'b0, 1'b0, 1'b1);
    flush = 1'b0;
    tick(1'b0, 1'b0, 1'b1);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b want=1", empty); end
    total++; if (level !== '0) begin bad++; $display("FAIL flush_level got=%0d want=0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_overflow got=%b want=0", overflow); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL flush_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_stall();
    logic [4:0] pat;
    pat = 5'b11001;
    run = 1'b1;
    rep_factor = 3'd3;
    clear_mon();
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick(1'b0, 1'b0, pat[i]);
      if (!pat[i]) begin
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stall%0d_valid got=%b want=1", i, out_valid); end
        total++; if (out_data !== 1'b1) begin bad++; $display("FAIL stall%0d_data got=%b want=1", i, out_data); end
      end
    end
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    total++; if (beats.size() !== 3) begin bad++; $display("FAIL stall_count got=%0d want=3", beats.size()); end
    for (int i = 0; i < beats.size(); i++) begin
      total++; if (beats[i] !== 1'b1) begin bad++; $display("FAIL stall_beat%0d got=%b want=1", i, beats[i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL stall_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_rep_change();
    logic [7:0] exp8;
    exp8 = 8'b000_11111;
    run = 1'b1;
    rep_factor = 3'd3;
    clear_mon();
    tick(1'b1, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    rep_factor = 3'd5;
    repeat (14) tick(1'b0, 1'b0, 1'b1);
    total++; if (beats.size() !== 8) begin bad++; $display("FAIL change_count got=%0d want=8", beats.size()); end
    for (int i = 0; i < 8 && i < beats.size(); i++) begin
      total++; if (beats[i] !== exp8[7-i]) begin bad++; $display("FAIL change_beat%0d got=%b want=%b", i, beats[i], exp8[7-i]); end
    end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL change_done got=%0d want=1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    run = 1'b1;
    rep_factor = 3'd3;
    clear_mon();
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b1);
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midreset_pre_valid got=%b want=1", out_valid); end
    #2 reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_valid got=%b want=0", out_valid); end
    total++; if (level !== '0) begin bad++; $display("FAIL midreset_level got=%0d want=0", level); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL midreset_empty got=%b want=1", empty); end
    @(negedge clk);
    reset = 1'b1;
    test_rep3();
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b1;
    test_rep3();
    test_bypass();
    test_full();
    test_stall();
    test_rep_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
